hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS32 core. It generates EX-stage operand forwarding selects and detects load-use hazards. It also sequences the decode-stage control-flow stall: it holds fetch while a BEQ/J/JAL resolves, flushes the wrong-path decode slot on a taken transfer, and returns the one-cycle `resume` pulse that releases the decode stage's `stall`. It sits beside the pipeline registers and drives their stall/flush enables.

## Interface

Parameters:
- MAX_WAIT, default 4: maximum cycles spent in WAIT before a forced release; legal range 2..15.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high
- rs_d, rt_d  in  5 each  source registers of the instruction in decode
- rs_e, rt_e  in  5 each  source registers of the instruction in EX
- mem_to_reg_e  in  1  EX instruction is a load
- reg_write_m  in  1  MEM instruction writes the register file
- write_reg_m  in  5  MEM destination register
- reg_write_w  in  1  WB instruction writes the register file
- write_reg_w  in  5  WB destination register
- ctrl_d  in  1  decode holds BEQ/J/JAL; level, held while decode is stalled
- resolve_m  in  1  control-flow outcome is valid this cycle (one-cycle pulse)
- taken_m  in  1  outcome is taken; qualified by resolve_m
- forward_a_e, forward_b_e  out  2 each  EX operand select: 00 = register file, 01 = WB result, 10 = MEM result
- stall_f  out  1  hold PC/fetch register
- stall_d  out  1  hold IF/ID register
- flush_d  out  1  clear IF/ID register
- flush_e  out  1  clear ID/EX register (insert bubble)
- resume  out  1  registered one-cycle release pulse to decode
- timeout_err  out  1  sticky; WAIT exceeded MAX_WAIT

## Operation

- Forwarding (combinational), shown for A; B is identical using rt_e:
  - 10 if reg_write_m, write_reg_m != 0, and write_reg_m == rs_e.
  - Else 01 if reg_write_w, write_reg_w != 0, and write_reg_w == rs_e.
  - Else 00. MEM has priority over WB.
- lw_stall = mem_to_reg_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d).
- FSM states: IDLE, WAIT, FLUSH. wait_cnt is $clog2(MAX_WAIT+1) bits wide and saturates.
- IDLE:
  - If lw_stall: assert stall_f, stall_d and flush_e; remain in IDLE.
  - Else if ctrl_d: go to WAIT and clear wait_cnt.
  - resolve_m is ignored in IDLE.
- WAIT:
  - stall_f = 1. stall_d, flush_d and flush_e = 0, since decode self-stalls. lw_stall is not evaluated. wait_cnt increments each cycle.
  - resolve_m && taken_m: go to FLUSH.
  - resolve_m && !taken_m: go to IDLE.
  - No resolve_m and wait_cnt == MAX_WAIT-1: go to IDLE and set timeout_err.
  - ctrl_d is ignored while in WAIT.
- FLUSH: flush_d = 1 and stall_f = 0 for exactly one cycle, then IDLE.
- resume is registered: it equals 1 in the cycle after any WAIT exit, whether by resolve or timeout.
- timeout_err clears only on rst.
- When lw_stall and ctrl_d are both true in IDLE, the load-use stall wins and the FSM stays in IDLE. ctrl_d is re-sampled next cycle.

## Timing

- Reset (asynchronous, immediate):
  - state = IDLE, wait_cnt = 0, resume = 0, timeout_err = 0.
  - stall_f, stall_d, flush_d and flush_e are forced to 0 while rst is high.
  - forward_a_e and forward_b_e = 00 while rst is high.
- Forwarding and load-use outputs have zero latency (same cycle as inputs).
- Control sequence, with ctrl_d first high in cycle T:
  - State is WAIT from T+1, with stall_f high from T+1.
  - resolve_m in cycle R (R ≥ T+1) gives resume = 1 in R+1.
  - If taken: flush_d = 1 in R+1.
  - State is IDLE in R+1 (not taken) or R+2 (taken).
- Timeout with no resolve_m: WAIT lasts exactly MAX_WAIT cycles; resume and timeout_err rise in cycle T+1+MAX_WAIT.
- Reset asserted mid-WAIT or mid-FLUSH: no resume pulse is emitted; the FSM restarts in IDLE.

## Test plan

- Forwarding priority: reg_write_m = reg_write_w = 1, write_reg_m = write_reg_w = rs_e = 5 -> forward_a_e = 10. Then reg_write_m = 0 -> 01. Then rs_e = 0 with both writers targeting register 0 -> 00.
- Load-use: mem_to_reg_e = 1, rt_e = 8, rs_d = 8 -> stall_f = stall_d = flush_e = 1 in the same cycle. Set rt_e = 0 -> all three = 0.
- Not-taken branch: ctrl_d at T, resolve_m = 1 with taken_m = 0 at T+2 -> stall_f high T+1..T+2, resume = 1 only at T+3, flush_d never asserted.
- Taken jump: ctrl_d at T, resolve_m = taken_m = 1 at T+1 -> flush_d = 1 and resume = 1 at T+2, state IDLE at T+3.
- Timeout: MAX_WAIT = 4, ctrl_d at T with no resolve -> resume = 1 and timeout_err = 1 at T+5. timeout_err stays 1 until rst.
- Async reset in WAIT: assert rst mid-cycle -> stall_f drops immediately; no resume pulse afterwards; timeout_err = 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side register/control info in, stall/flush/forward out.
interface hazard_ctrl_if;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [4:0] rs_e;
  logic [4:0] rt_e;
  logic       mem_to_reg_e;
  logic       reg_write_m;
  logic [4:0] write_reg_m;
  logic       reg_write_w;
  logic [4:0] write_reg_w;
  logic       ctrl_d;
  logic       resolve_m;
  logic       taken_m;
  logic [1:0] forward_a_e;
  logic [1:0] forward_b_e;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;
  logic       resume;
  logic       timeout_err;

  // Pipeline side drives hazard inputs and consumes the enables
  modport master (
    output rs_d, rt_d, rs_e, rt_e, mem_to_reg_e,
    output reg_write_m, write_reg_m, reg_write_w, write_reg_w,
    output ctrl_d, resolve_m, taken_m,
    input  forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
    input  resume, timeout_err
  );

  // Controller side
  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, mem_to_reg_e,
    input  reg_write_m, write_reg_m, reg_write_w, write_reg_w,
    input  ctrl_d, resolve_m, taken_m,
    output forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
    output resume, timeout_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use stall, control-flow wait/flush sequencing.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 4  // legal 2..15
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int unsigned   CntW    = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  typedef enum logic [1:0] {StIdle, StWait, StFlush} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CntW-1:0] r_wait_cnt;
  logic            r_resume;
  logic            r_timeout_err;

  logic       w_lw_stall;
  logic       w_wait_exit;
  logic       w_timeout;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // MEM result has priority over WB; register 0 is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       rw_m,
                                         input logic [4:0] wr_m,
                                         input logic       rw_w,
                                         input logic [4:0] wr_w);
    if (rw_m && (wr_m != 5'd0) && (wr_m == src)) begin
      return 2'b10;
    end else if (rw_w && (wr_w != 5'd0) && (wr_w == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // Forwarding selects and load-use detection, zero latency
  always_comb begin
    w_fwd_a    = fwd_sel(bus.rs_e, bus.reg_write_m, bus.write_reg_m,
                         bus.reg_write_w, bus.write_reg_w);
    w_fwd_b    = fwd_sel(bus.rt_e, bus.reg_write_m, bus.write_reg_m,
                         bus.reg_write_w, bus.write_reg_w);
    w_lw_stall = bus.mem_to_reg_e && (bus.rt_e != 5'd0) &&
                 ((bus.rt_e == bus.rs_d) || (bus.rt_e == bus.rt_d));
  end

  // WAIT exits on any resolve, or on the last allowed cycle without one
  always_comb begin
    w_timeout   = (r_state == StWait) && !bus.resolve_m && (r_wait_cnt == CntLast);
    w_wait_exit = (r_state == StWait) && (bus.resolve_m || (r_wait_cnt == CntLast));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a load-use stall in IDLE defers ctrl_d to the next cycle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_lw_stall && bus.ctrl_d) begin
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        if (bus.resolve_m) begin
          w_state_nxt = bus.taken_m ? StFlush : StIdle;
        end else if (r_wait_cnt == CntLast) begin
          w_state_nxt = StIdle;
        end
      end
      StFlush: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Wait counter (saturating), registered resume pulse, sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_resume      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == StIdle) && (w_state_nxt == StWait)) begin
        r_wait_cnt <= '0;
      end else if ((r_state == StWait) && (r_wait_cnt != CntMax)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      r_resume <= w_wait_exit;
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Output decode; every enable is forced low while reset is held
  always_comb begin
    bus.stall_f     = 1'b0;
    bus.stall_d     = 1'b0;
    bus.flush_d     = 1'b0;
    bus.flush_e     = 1'b0;
    bus.forward_a_e = 2'b00;
    bus.forward_b_e = 2'b00;
    bus.resume      = r_resume;
    bus.timeout_err = r_timeout_err;
    if (!rst) begin
      bus.forward_a_e = w_fwd_a;
      bus.forward_b_e = w_fwd_b;
      unique case (r_state)
        StIdle: begin
          bus.stall_f = w_lw_stall;
          bus.stall_d = w_lw_stall;
          bus.flush_e = w_lw_stall;
        end
        // Decode stalls itself while waiting, so only fetch is held here
        StWait:  bus.stall_f = 1'b1;
        StFlush: bus.flush_d = 1'b1;
        default: bus.stall_f = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a cycle-history reference model.
module tb_hazard_ctrl;

  localparam int unsigned MaxWait = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MAX_WAIT(MaxWait)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus for the next cycle
  logic [4:0] s_rs_d, s_rt_d, s_rs_e, s_rt_e, s_wr_m, s_wr_w;
  logic       s_m2r, s_rw_m, s_rw_w, s_ctrl, s_res, s_tkn, s_rst;

  // Reference model: what the controller is doing, in terms of elapsed cycles
  bit m_waiting;      // a control transfer is outstanding
  int m_wait_cycles;  // WAIT cycles elapsed including the current one
  bit m_flushing;     // this cycle squashes the wrong-path decode slot
  bit m_resume;
  bit m_terr;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (s_rw_m && s_wr_m != 0 && s_wr_m == src) return 2'b10;
    if (s_rw_w && s_wr_w != 0 && s_wr_w == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_stim();
    {s_rs_d, s_rt_d, s_rs_e, s_rt_e, s_wr_m, s_wr_w} = '0;
    {s_m2r, s_rw_m, s_rw_w, s_ctrl, s_res, s_tkn, s_rst} = '0;
  endtask

  task automatic model_reset();
    m_waiting = 0; m_wait_cycles = 0; m_flushing = 0; m_resume = 0; m_terr = 0;
  endtask

  // One clock cycle: apply stimulus, check outputs mid-cycle, then advance the model
  task automatic tick();
    bit lw;
    logic [1:0] e_fa, e_fb;
    bit e_sf, e_sd, e_fd, e_fe;
    @(negedge clk);
    bus.rs_d = s_rs_d; bus.rt_d = s_rt_d; bus.rs_e = s_rs_e; bus.rt_e = s_rt_e;
    bus.mem_to_reg_e = s_m2r; bus.reg_write_m = s_rw_m; bus.write_reg_m = s_wr_m;
    bus.reg_write_w = s_rw_w; bus.write_reg_w = s_wr_w;
    bus.ctrl_d = s_ctrl; bus.resolve_m = s_res; bus.taken_m = s_tkn;
    rst = s_rst;
    if (s_rst) model_reset();
    #1;
    lw = s_m2r && s_rt_e != 0 && (s_rt_e == s_rs_d || s_rt_e == s_rt_d);
    e_fa = ref_fwd(s_rs_e);
    e_fb = ref_fwd(s_rt_e);
    e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0;
    if (s_rst) begin
      e_fa = 2'b00; e_fb = 2'b00;
    end else if (m_waiting) begin
      e_sf = 1;
    end else if (m_flushing) begin
      e_fd = 1;
    end else begin
      e_sf = lw; e_sd = lw; e_fe = lw;
    end
    check("fwd_a", 8'(bus.forward_a_e), 8'(e_fa));
    check("fwd_b", 8'(bus.forward_b_e), 8'(e_fb));
    check("stall_f", 8'(bus.stall_f), 8'(e_sf));
    check("stall_d", 8'(bus.stall_d), 8'(e_sd));
    check("flush_d", 8'(bus.flush_d), 8'(e_fd));
    check("flush_e", 8'(bus.flush_e), 8'(e_fe));
    check("resume", 8'(bus.resume), 8'(m_resume));
    check("timeout_err", 8'(bus.timeout_err), 8'(m_terr));
    @(posedge clk);
    if (!s_rst) begin
      if (m_waiting) begin
        if (s_res) begin
          m_waiting = 0; m_flushing = s_tkn; m_resume = 1;
        end else if (m_wait_cycles == MaxWait) begin
          m_waiting = 0; m_resume = 1; m_terr = 1;
        end else begin
          m_wait_cycles++; m_resume = 0;
        end
      end else if (m_flushing) begin
        m_flushing = 0; m_resume = 0;
      end else begin
        m_resume = 0;
        if (!lw && s_ctrl) begin
          m_waiting = 1; m_wait_cycles = 1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    clear_stim();
    s_rst = 1;
    tick();                                    // reset state
    s_rst = 0;
    tick();

    // Forwarding priority: MEM over WB, then WB, then register 0 never forwards
    s_rw_m = 1; s_rw_w = 1; s_wr_m = 5; s_wr_w = 5; s_rs_e = 5; tick();
    s_rw_m = 0; tick();
    s_rs_e = 0; s_wr_m = 0; s_wr_w = 0; s_rw_m = 1; tick();
    clear_stim();

    // Load-use stall and its release when rt_e is register 0; also beats ctrl_d
    s_m2r = 1; s_rt_e = 8; s_rs_d = 8; s_ctrl = 1; tick();
    s_rt_e = 0; s_ctrl = 0; tick();
    clear_stim(); tick();

    // Not-taken branch resolved two cycles after ctrl_d
    s_ctrl = 1; tick(); tick();
    s_ctrl = 0; s_res = 1; tick();
    clear_stim(); tick(); tick();

    // Taken jump resolved immediately
    s_ctrl = 1; tick();
    s_ctrl = 0; s_res = 1; s_tkn = 1; tick();
    clear_stim(); tick(); tick();

    // Timeout with no resolve, then sticky flag
    s_ctrl = 1; tick();
    s_ctrl = 0;
    for (int i = 0; i < MaxWait + 3; i++) tick();

    // Reset in the middle of WAIT clears everything, no resume afterwards
    s_ctrl = 1; tick();
    s_ctrl = 0; tick();
    s_rst = 1; tick();
    s_rst = 0; tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      s_rs_d = 5'($urandom_range(0, 3)); s_rt_d = 5'($urandom_range(0, 3));
      s_rs_e = 5'($urandom_range(0, 3)); s_rt_e = 5'($urandom_range(0, 3));
      s_wr_m = 5'($urandom_range(0, 3)); s_wr_w = 5'($urandom_range(0, 3));
      s_m2r  = ($urandom_range(0, 2) == 0);
      s_rw_m = $urandom_range(0, 1); s_rw_w = $urandom_range(0, 1);
      s_ctrl = ($urandom_range(0, 3) == 0);
      s_res  = ($urandom_range(0, 5) == 0);
      s_tkn  = $urandom_range(0, 1);
      s_rst  = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
